// File: rtl/iterative_shifter.sv
// iterative_shifter: multi-cycle shift unit that moves the operand one bit
// position per clock. Supports logical left, logical right, arithmetic right
// and rotate left under a start/done handshake.
// Optional feature: define SHIFTER_ABORT_EN to add an 'abort' input that
// cancels an in-flight operation without producing a result.
module iterative_shifter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   data_in,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [1:0]         op,
`ifdef SHIFTER_ABORT_EN
   input  logic               abort,
`endif
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   result
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   typedef enum logic [1:0] {
      OP_SLL = 2'b00,
      OP_SRL = 2'b01,
      OP_SRA = 2'b10,
      OP_ROL = 2'b11
   } shiftOp_t;

   state_t             state_q;
   shiftOp_t           op_q;
   logic [WIDTH-1:0]   work_q;
   logic [WIDTH-1:0]   work_d;
   logic [SHAMT_W-1:0] count_q;
   logic [WIDTH-1:0]   result_q;
   logic               busy_q;
   logic               done_q;

   // One-bit step of the working register according to the captured mode
   always_comb begin
      work_d = work_q;
      case (op_q)
         OP_SLL:  work_d = {work_q[WIDTH-2:0], 1'b0};
         OP_SRL:  work_d = {1'b0, work_q[WIDTH-1:1]};
         OP_SRA:  work_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         OP_ROL:  work_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
         default: work_d = work_q;
      endcase
   end

   // Control FSM with registered busy/done/result; a zero shift amount skips
   // straight to DONE, and a request arriving in DONE is taken without a bubble
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= OP_SLL;
         work_q   <= '0;
         count_q  <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  work_q  <= data_in;
                  op_q    <= shiftOp_t'(op);
                  count_q <= shamt;
                  if (shamt != '0) begin
                     state_q <= SHIFT;
                     busy_q  <= 1'b1;
                  end else begin
                     state_q  <= DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     result_q <= data_in;
                  end
               end else begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            SHIFT: begin
`ifdef SHIFTER_ABORT_EN
               if (abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  work_q  <= '0;
                  count_q <= '0;
               end else
`endif
               begin
                  work_q  <= work_d;
                  count_q <= count_q - SHAMT_W'(1);
                  if (count_q == SHAMT_W'(1)) begin
                     state_q  <= DONE;
                     busy_q   <= 1'b0;
                     done_q   <= 1'b1;
                     result_q <= work_d;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_iterative_shifter.sv
// tb_iterative_shifter: directed tests for iterative_shifter covering each
// shift mode, zero-length shifts, handshake behaviour and reset mid-operation.
// The abort scenario is included when SHIFTER_ABORT_EN is defined.
module tb_iterative_shifter;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] dataIn;
   logic [4:0]  shamt;
   logic [1:0]  op;
`ifdef SHIFTER_ABORT_EN
   logic        abort;
`endif
   logic        busy;
   logic        done;
   logic [31:0] result;

   int checks = 0;
   int errors = 0;

   iterative_shifter #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clock   (clock),
      .reset   (reset),
      .start   (start),
      .data_in (dataIn),
      .shamt   (shamt),
      .op      (op),
`ifdef SHIFTER_ABORT_EN
      .abort   (abort),
`endif
      .busy    (busy),
      .done    (done),
      .result  (result)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Advance to 1 time unit after the next rising edge
   task automatic nextCycle();
      @(posedge clock);
      #1;
   endtask

   // Issue one request and follow it to completion (bounded). Cycle 0 is the
   // cycle in which start is presented; doneCyc is -1 on timeout.
   task automatic applyStimulus(input logic [31:0] d, input logic [4:0] s,
                                input logic [1:0] o, output int doneCyc,
                                output int busyCnt, output logic overlap,
                                output logic resChanged, output logic [31:0] res);
      logic [31:0] resBefore;
      resBefore  = result;
      doneCyc    = -1;
      busyCnt    = 0;
      overlap    = 1'b0;
      resChanged = 1'b0;
      res        = 32'h0;
      start  = 1'b1;
      dataIn = d;
      shamt  = s;
      op     = o;
      nextCycle();
      start = 1'b0;
      for (int cyc = 1; cyc <= 60; cyc++) begin
         if (busy && done) overlap = 1'b1;
         if (busy) busyCnt++;
         if (done) begin
            doneCyc = cyc;
            res     = result;
            break;
         end
         if (result !== resBefore) resChanged = 1'b1;
         nextCycle();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      dataIn = '0;
      shamt = '0;
      op = '0;
`ifdef SHIFTER_ABORT_EN
      abort = 1'b0;
`endif
      nextCycle();
      nextCycle();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got %b want 0", done); end
      checks++;
      if (result !== 32'h0) begin errors++; $display("[TB] FAIL reset_result got %h want 00000000", result); end
      reset = 1'b0;
      nextCycle();
   endtask

   task automatic test_sll();
      int dc, bc; logic ov, rc; logic [31:0] r;
      applyStimulus(32'h0000_0001, 5'd31, 2'b00, dc, bc, ov, rc, r);
      checks++;
      if (dc != 32) begin errors++; $display("[TB] FAIL sll31_done_cycle got %0d want 32", dc); end
      checks++;
      if (bc != 31) begin errors++; $display("[TB] FAIL sll31_busy_cycles got %0d want 31", bc); end
      checks++;
      if (r !== 32'h8000_0000) begin errors++; $display("[TB] FAIL sll31_result got %h want 80000000", r); end
      checks++;
      if (ov || rc) begin errors++; $display("[TB] FAIL sll31_stability got overlap=%b resChanged=%b want 0 0", ov, rc); end
      nextCycle();
   endtask

   task automatic test_shift_right();
      int dc, bc; logic ov, rc; logic [31:0] r;
      applyStimulus(32'h8000_0000, 5'd4, 2'b10, dc, bc, ov, rc, r);
      checks++;
      if (dc != 5) begin errors++; $display("[TB] FAIL sra4_done_cycle got %0d want 5", dc); end
      checks++;
      if (r !== 32'hF800_0000) begin errors++; $display("[TB] FAIL sra4_result got %h want f8000000", r); end
      nextCycle();
      applyStimulus(32'h8000_0000, 5'd4, 2'b01, dc, bc, ov, rc, r);
      checks++;
      if (dc != 5) begin errors++; $display("[TB] FAIL srl4_done_cycle got %0d want 5", dc); end
      checks++;
      if (r !== 32'h0800_0000) begin errors++; $display("[TB] FAIL srl4_result got %h want 08000000", r); end
      nextCycle();
   endtask

   task automatic test_rotate();
      int dc, bc; logic ov, rc; logic [31:0] r;
      applyStimulus(32'h8000_0001, 5'd1, 2'b11, dc, bc, ov, rc, r);
      checks++;
      if (dc != 2) begin errors++; $display("[TB] FAIL rol1_done_cycle got %0d want 2", dc); end
      checks++;
      if (r !== 32'h0000_0003) begin errors++; $display("[TB] FAIL rol1_result got %h want 00000003", r); end
      nextCycle();
      applyStimulus(32'h1234_5678, 5'd0, 2'b11, dc, bc, ov, rc, r);
      checks++;
      if (dc != 1) begin errors++; $display("[TB] FAIL zero_done_cycle got %0d want 1", dc); end
      checks++;
      if (bc != 0) begin errors++; $display("[TB] FAIL zero_busy_cycles got %0d want 0", bc); end
      checks++;
      if (r !== 32'h1234_5678) begin errors++; $display("[TB] FAIL zero_result got %h want 12345678", r); end
      nextCycle();
   endtask

   task automatic test_back_to_back();
      int cyc; int dc, bc; logic ov, rc; logic [31:0] r;
      start  = 1'b1;
      dataIn = 32'h0000_0003;
      shamt  = 5'd5;
      op     = 2'b00;
      nextCycle();
      start = 1'b0;
      cyc = 1;
      nextCycle();
      cyc = 2;
      start  = 1'b1;
      dataIn = 32'hFFFF_FFFF;
      shamt  = 5'd1;
      op     = 2'b01;
      nextCycle();
      cyc = 3;
      start = 1'b0;
      while (!done && cyc < 40) begin
         nextCycle();
         cyc++;
      end
      checks++;
      if (cyc != 6) begin errors++; $display("[TB] FAIL ignore_start_done_cycle got %0d want 6", cyc); end
      checks++;
      if (result !== 32'h0000_0060) begin errors++; $display("[TB] FAIL ignore_start_result got %h want 00000060", result); end
      applyStimulus(32'h0000_000F, 5'd3, 2'b11, dc, bc, ov, rc, r);
      checks++;
      if (dc != 4) begin errors++; $display("[TB] FAIL b2b_done_cycle got %0d want 4", dc); end
      checks++;
      if (bc != 3) begin errors++; $display("[TB] FAIL b2b_busy_cycles got %0d want 3", bc); end
      checks++;
      if (r !== 32'h0000_0078) begin errors++; $display("[TB] FAIL b2b_result got %h want 00000078", r); end
      nextCycle();
   endtask

   task automatic test_reset_mid();
      int doneSeen;
      start  = 1'b1;
      dataIn = 32'hFFFF_0000;
      shamt  = 5'd10;
      op     = 2'b01;
      nextCycle();
      start = 1'b0;
      nextCycle();
      nextCycle();
      reset = 1'b1;
      #1;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy got %b want 0", busy); end
      checks++;
      if (done !== 1'b0) begin errors++; $display("[TB] FAIL midreset_done got %b want 0", done); end
      checks++;
      if (result !== 32'h0) begin errors++; $display("[TB] FAIL midreset_result got %h want 00000000", result); end
      nextCycle();
      reset = 1'b0;
      doneSeen = 0;
      for (int i = 0; i < 15; i++) begin
         nextCycle();
         if (done || busy) doneSeen++;
      end
      checks++;
      if (doneSeen != 0) begin errors++; $display("[TB] FAIL midreset_activity got %0d want 0", doneSeen); end
   endtask

`ifdef SHIFTER_ABORT_EN
   task automatic test_abort();
      int dc, bc; logic ov, rc; logic [31:0] r; int activity;
      applyStimulus(32'hCAFE_F00D, 5'd0, 2'b00, dc, bc, ov, rc, r);
      nextCycle();
      start  = 1'b1;
      dataIn = 32'h0000_0001;
      shamt  = 5'd8;
      op     = 2'b00;
      nextCycle();
      start = 1'b0;
      nextCycle();
      nextCycle();
      abort = 1'b1;
      nextCycle();
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("[TB] FAIL abort_busy got %b want 0", busy); end
      activity = 0;
      for (int i = 0; i < 12; i++) begin
         if (done) activity++;
         nextCycle();
      end
      checks++;
      if (activity != 0) begin errors++; $display("[TB] FAIL abort_done_pulses got %0d want 0", activity); end
      checks++;
      if (result !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL abort_result got %h want cafef00d", result); end
   endtask
`endif

   // Run every scenario in order, then report
   initial begin
      test_reset();
      test_sll();
      test_shift_right();
      test_rotate();
      test_back_to_back();
      test_reset_mid();
`ifdef SHIFTER_ABORT_EN
      test_abort();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
Multi-cycle, parametrised shift unit for the pipeline processor's ALU/multdiv path. It supersedes the fixed single-bit left-shift primitives. It accepts an operand, shift amount and operation, then shifts one bit position per cycle under a start/done handshake. Four modes are supported: logical left, logical right, arithmetic right and rotate left.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2).
SHAMT_W, 5, shift-amount width; legal amounts 0..2^SHAMT_W-1, required 2^SHAMT_W <= WIDTH.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; sampled on rising edge while state is IDLE or DONE.
data_in  input  WIDTH  operand, captured when start is accepted.
shamt  input  SHAMT_W  shift amount, captured when start is accepted.
op  input  2  mode, captured when start is accepted: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
busy  output  1  high while state is SHIFT.
done  output  1  one-cycle pulse; result valid.
result  output  WIDTH  last completed result; held until the next completion.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; busy=0; done=0; result=0; working register, counter and captured op all cleared.
- States:
  - IDLE: waiting.
  - SHIFT: shifting in progress.
  - DONE: single cycle, done=1.
- Acceptance:
  - start=1 in IDLE or DONE captures data_in, shamt and op.
  - Next state is SHIFT with count=shamt when shamt!=0; otherwise next state is DONE.
- SHIFT, each edge: working register shifts one position per op.
  - SLL: 0 fills the LSB.
  - SRL: 0 fills the MSB.
  - SRA: the MSB is replicated.
  - ROL: the old MSB enters the LSB.
  - count decrements. When count==1 at the edge, the final shift is performed and next state is DONE.
- Entry to DONE: result loads the final working value on the same edge. done=1 for exactly that cycle.
- DONE: with start=0, next state is IDLE. With start=1, the new request is accepted (back-to-back operation, no bubble).
- Latency: if start is accepted in cycle 0, done is high in cycle shamt+1. Examples: shamt=0 gives done in cycle 1; shamt=31 gives done in cycle 32.
- start while busy=1: ignored; in-flight operation and captured operands are unaffected.
- Operands are captured: changes to data_in, shamt or op after acceptance have no effect.
- result changes only on entry to DONE or on reset; it is stable in IDLE and SHIFT.
- busy and done are never high simultaneously.
- Reset asserted mid-operation: immediate return to IDLE, no done pulse, result=0.
- Counter width is SHAMT_W. No overflow is possible because the counter only decrements from the captured shamt.

Optional Feature:
Macro SHIFTER_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 sampled in SHIFT forces next state IDLE. No done pulse. result keeps its previous value. The working register is discarded.
  - abort has priority over the count==1 transition.
  - abort in IDLE or DONE is ignored; in DONE the done pulse still occurs and start handling is unchanged.
- Undefined: no abort port; an operation always runs to completion unless reset is asserted.

Test Plan:
1. SLL, data_in=0x00000001, shamt=31 -> busy high in cycles 1..31, done in cycle 32, result=0x80000000.
2. SRA, data_in=0x80000000, shamt=4 -> done in cycle 5, result=0xF8000000. Same operand with SRL -> result=0x08000000.
3. ROL, data_in=0x80000001, shamt=1 -> done in cycle 2, result=0x00000003. shamt=0 with data_in=0x12345678 -> done in cycle 1, result=0x12345678, busy never high.
4. start pulsed again in cycle 2 of an SLL shamt=5 run with different data_in -> ignored; done in cycle 6 with the original result. A new start asserted during the done cycle -> accepted, next done after shamt+1 cycles.
5. reset asserted in cycle 3 of an SRL shamt=10 run -> busy=0, done=0 and result=0 immediately; no done pulse follows.
6. (SHIFTER_ABORT_EN) abort in cycle 3 of an SLL shamt=8 run, with previous result=0xCAFEF00D -> returns to IDLE, no done pulse, result remains 0xCAFEF00D.
